// File: rtl/updown_count_scheduler_if.sv
// Request/acknowledge and counter-control bundle shared between the up/down
// requesters and the scheduler that owns the counter's mode and enable.
interface updown_count_scheduler_if #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 3
);
    logic              up_req;
    logic [STEP_W-1:0] up_steps;
    logic              up_ack;
    logic              dn_req;
    logic [STEP_W-1:0] dn_steps;
    logic              dn_ack;
    logic              M;
    logic              cnt_en;
    logic              busy;
    logic              owner;
    logic              done;
    logic              sat;
    logic [WIDTH-1:0]  count;

    modport master (
        output up_req, up_steps, dn_req, dn_steps,
        input  up_ack, dn_ack, M, cnt_en, busy, owner, done, sat, count
    );

    modport slave (
        input  up_req, up_steps, dn_req, dn_steps,
        output up_ack, dn_ack, M, cnt_en, busy, owner, done, sat, count
    );
endinterface

// File: rtl/updown_count_scheduler.sv
// Round-robin burst scheduler driving the mode and enable of a shared up/down
// counter, with a shadow count used to wrap or saturate at the counter limits.
module updown_count_scheduler #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 3,
    parameter bit WRAP   = 1'b1
) (
    input logic                   clk,
    input logic                   clear,
    updown_count_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  COUNT_ONE = WIDTH'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              mode_q, mode_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              done_q, done_d;
    logic              sat_q, sat_d;
    logic              up_ack_q, up_ack_d;
    logic              dn_ack_q, dn_ack_d;
    logic              grant_dn;
    logic [STEP_W-1:0] steps_sel;

    // A step is refused only in saturating mode, and only when it would cross the limit.
    function automatic logic blocked(input logic [WIDTH-1:0] value, input logic down);
        logic at_limit;
        at_limit = down ? (value == '0) : (value == '1);
        return (WRAP == 1'b0) && at_limit;
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            mode_q      <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b1;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            up_ack_q    <= 1'b0;
            dn_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
            up_ack_q    <= up_ack_d;
            dn_ack_q    <= dn_ack_d;
        end
    end

    // Every output is registered, so the step issued in the next cycle is decided
    // here from the count and remaining values that this edge will produce.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        mode_d      = mode_q;
        owner_d     = owner_q;
        en_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sat_d       = 1'b0;
        up_ack_d    = 1'b0;
        dn_ack_d    = 1'b0;
        grant_dn    = 1'b0;
        steps_sel   = '0;

        if (en_q) begin
            count_d     = mode_q ? (count_q - COUNT_ONE) : (count_q + COUNT_ONE);
            remaining_d = remaining_q - STEP_ONE;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.up_req || bus.dn_req) begin
                    grant_dn    = (bus.up_req && bus.dn_req) ? ~owner_q : bus.dn_req;
                    steps_sel   = grant_dn ? bus.dn_steps : bus.up_steps;
                    owner_d     = grant_dn;
                    mode_d      = grant_dn;
                    busy_d      = 1'b1;
                    up_ack_d    = ~grant_dn;
                    dn_ack_d    = grant_dn;
                    remaining_d = steps_sel;
                    if (steps_sel == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (blocked(count_q, grant_dn)) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        sat_d       = 1'b1;
                        remaining_d = '0;
                    end else begin
                        state_d = RUN;
                        en_d    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (remaining_d == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (blocked(count_d, mode_q)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    sat_d       = 1'b1;
                    remaining_d = '0;
                end else begin
                    en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.up_ack = up_ack_q;
    assign bus.dn_ack = dn_ack_q;
    assign bus.M      = mode_q;
    assign bus.cnt_en = en_q;
    assign bus.busy   = busy_q;
    assign bus.owner  = owner_q;
    assign bus.done   = done_q;
    assign bus.sat    = sat_q;
    assign bus.count  = count_q;

endmodule

// File: doc/updown_count_scheduler.md
Name: updown_count_scheduler

Overview:
Shares one 3-bit synchronous up/down counter datapath between an "up" requester and a "down" requester. Each request is a burst of N steps. The block arbitrates round-robin between the two requesters. It drives the counter's mode (M) and count-enable for exactly N cycles and keeps a shadow copy of the count so it can enforce limits. It sits directly in front of the T-flip-flop up/down counter and owns its M and enable inputs.

Parameters:
WIDTH, 3, counter width; also the width of the count shadow.
STEP_W, 3, width of the step-count fields (max burst 2^STEP_W-1).
WRAP, 1, 1 = counter wraps (7->0, 0->7); 0 = saturate: burst aborts at limit.

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous, active-high reset
up_req  input  1  up requester wants a burst; held until up_ack
up_steps  input  STEP_W  step count for up burst; stable while up_req high
up_ack  output  1  one-cycle pulse: up request accepted, steps latched
dn_req  input  1  down requester wants a burst; held until dn_ack
dn_steps  input  STEP_W  step count for down burst
dn_ack  output  1  one-cycle pulse: down request accepted
M  output  1  counter mode: 0 = count up, 1 = count down
cnt_en  output  1  counter advances on this clk edge when high
busy  output  1  high in every state except IDLE
owner  output  1  current or last grant: 0 = up, 1 = down
done  output  1  one-cycle pulse at end of burst
sat  output  1  one-cycle pulse, coincident with done, when burst aborted at limit (WRAP=0 only)
count  output  WIDTH  shadow of counter value

Behaviour:
- All outputs are registered. Reset (clear=1 at an edge) produces:
  - state=IDLE
  - M=0, cnt_en=0, busy=0, up_ack=0, dn_ack=0, done=0, sat=0, count=0
  - owner=1, so up wins the first contention
  - internal remaining=0
- clear takes priority over every other event, including mid-RUN. A burst that is in flight is dropped with no done pulse and no ack. Requesters must re-request.
- States are IDLE, RUN and DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, that requester is granted.
  - If both are high, the requester opposite to owner is granted (round-robin).
  - On grant at edge t:
    - latch steps into remaining
    - owner <= grantee; M <= grantee (0 up, 1 down)
    - matching ack=1 during cycle t+1 only; busy=1
    - next state is RUN if steps!=0, else DONE
  - With no req: stay in IDLE, M holds its previous value, cnt_en=0.
- RUN:
  - cnt_en=1 in each cycle where remaining!=0 and the limit check passes. remaining decrements and count updates by +1 or -1 mod 2^WIDTH at that edge. This matches the counter, so count always equals the counter's Q.
  - Exactly N cnt_en cycles for a burst of N. Latency: grant at edge t, cnt_en high in cycles t+1..t+N, done in cycle t+N+1, IDLE (ready for the next grant) in cycle t+N+2.
  - M is constant throughout RUN and DONE. It changes only on a grant edge and never in the same cycle as cnt_en=1 with a different direction.
  - When WRAP=0 and the next step would cross a limit (count==2^WIDTH-1 going up, or count==0 going down), cnt_en is not asserted. The FSM goes to DONE with sat=1, and the unused remaining is discarded.
  - When WRAP=1, 7->0 and 0->7 are ordinary steps.
- DONE:
  - done=1 (plus sat if the burst aborted) for one cycle, cnt_en=0, busy=1.
  - Next state is IDLE unconditionally.
- A requester holding req through its ack and on into DONE is granted again in IDLE only if the other requester is idle (round-robin).
- Arithmetic:
  - count is modulo 2^WIDTH.
  - remaining is unsigned STEP_W.
  - No step is issued once remaining is 0.

Test Plan:
- Reset then single up burst: clear 2 cycles; up_req=1, up_steps=5 → up_ack one cycle after grant; cnt_en high 5 consecutive cycles with M=0; count 0→5; done one cycle later; busy low the next cycle.
- Contention round-robin: both req high from reset (up_steps=2, dn_steps=3) → up granted first (count 0→2, done), then down granted (M=1, count 2→7 wrap via 0 with WRAP=1... i.e. 2→1→0→7), owner=1.
- Wrap vs saturate: count=6, up burst of 3 → WRAP=1: count ends at 1, sat=0. WRAP=0: only 1 cnt_en cycle (6→7), then done=1 and sat=1 together, count=7.
- Zero-step request: dn_req with dn_steps=0 → dn_ack pulse, no cnt_en, done the cycle after grant, count unchanged.
- Reset mid-burst: up burst of 7, assert clear after 3 cnt_en cycles → next cycle all outputs at reset values, count=0, no done pulse; a subsequent up request is granted normally.
- Back-to-back from the same requester: up_req held high with steps=1, dn_req low → grants repeat every 4 cycles (grant, RUN, DONE, IDLE), count increments 1 per burst, M stays 0.
